// File: rtl/timer_regs.sv
// timer_regs: bus-mapped control/status registers for a 64-bit timer.
// Map (addr[4:2]): 0 CTRL, 1 STATUS, 2 CMP_LO, 3 CMP_HI, 4 COUNT_LO, 5 COUNT_HI.
// Optional macro TIMER_REGS_SNAPSHOT_EN: COUNT_LO reads latch counter[63:32]
// into a hold register returned by COUNT_HI reads (default: COUNT_HI is live).
module timer_regs #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              gnt,
   output logic              rvalid,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [63:0]       cmp_value,
   output logic              start_timer,
   output logic              timer_en,
   output logic              interrupt_en,
   output logic              auto_reload,
   input  logic              done,
   input  logic              irq,
   input  logic [63:0]       counter,
   output logic              irq_o
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_STATUS   = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_COUNT_LO = 3'd4;
   localparam logic [2:0] OFF_COUNT_HI = 3'd5;

   logic [2:0]  off;
   logic        bad_c;
   logic        wr_c;
   logic        rd_c;
   logic [1:0]  clr_c;
   logic [31:0] rdata_c;
   logic [31:0] count_hi_c;
   logic [31:0] shadow;
   logic        done_flag;
   logic        irq_flag;

   assign gnt   = req;
   assign off   = addr[4:2];
   assign irq_o = irq_flag;

   // Decode: misaligned, unmapped and COUNT writes are errors with no side effects
   always_comb begin
      bad_c = (addr[1:0] != 2'b00) || (off > OFF_COUNT_HI) ||
              (we && ((off == OFF_COUNT_LO) || (off == OFF_COUNT_HI)));
      wr_c  = req && we && !bad_c;
      rd_c  = req && !we && !bad_c;
      clr_c = (wr_c && (off == OFF_STATUS)) ? wdata[1:0] : 2'b00;
   end

`ifdef TIMER_REGS_SNAPSHOT_EN
   logic [31:0] count_hold;

   // Capture the upper counter half alongside a COUNT_LO read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_hold <= '0;
      end else if (rd_c && (off == OFF_COUNT_LO)) begin
         count_hold <= counter[63:32];
      end
   end

   assign count_hi_c = count_hold;
`else
   assign count_hi_c = counter[63:32];
`endif

   // Read mux over pre-update register state
   always_comb begin
      rdata_c = '0;
      if (rd_c) begin
         case (off)
            OFF_CTRL:     rdata_c = {29'b0, auto_reload, interrupt_en, timer_en};
            OFF_STATUS:   rdata_c = {30'b0, irq_flag, done_flag};
            OFF_CMP_LO:   rdata_c = shadow;
            OFF_CMP_HI:   rdata_c = cmp_value[63:32];
            OFF_COUNT_LO: rdata_c = counter[31:0];
            OFF_COUNT_HI: rdata_c = count_hi_c;
            default:      rdata_c = '0;
         endcase
      end
   end

   // Bus response: one registered beat per granted request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= req;
         err    <= req && bad_c;
         rdata  <= rdata_c;
      end
   end

   // Control fields, start pulse and 64-bit compare value with atomic high-word commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_en     <= 1'b0;
         interrupt_en <= 1'b0;
         auto_reload  <= 1'b0;
         start_timer  <= 1'b0;
         shadow       <= '0;
         cmp_value    <= '0;
      end else begin
         start_timer <= wr_c && (off == OFF_CTRL) && wdata[3];
         if (wr_c && (off == OFF_CTRL)) begin
            timer_en     <= wdata[0];
            interrupt_en <= wdata[1];
            auto_reload  <= wdata[2];
         end
         if (wr_c && (off == OFF_CMP_LO)) begin
            shadow <= wdata;
         end
         if (wr_c && (off == OFF_CMP_HI)) begin
            cmp_value <= {wdata, shadow};
         end
      end
   end

   // Sticky flags: a set in the same cycle wins over a W1C clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_flag <= 1'b0;
         irq_flag  <= 1'b0;
      end else begin
         done_flag <= done || (done_flag && !clr_c[0]);
         irq_flag  <= irq  || (irq_flag  && !clr_c[1]);
      end
   end

endmodule

// File: tb/tb_timer_regs.sv
// Bench for timer_regs: random bus traffic against a register-map model,
// with bus responses checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_timer_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic [63:0] cmp_value;
   logic        start_timer, timer_en, interrupt_en, auto_reload;
   logic        done, irq;
   logic [63:0] counter;
   logic        irq_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;
   resp_t exp_q[$];

   // reference model state
   bit        m_ten, m_ien, m_ar, m_start, m_done, m_irq;
   bit [63:0] m_cmp;
   bit [31:0] m_shadow, m_hold;

   always #5 clk = ~clk;

   timer_regs #(.ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
      .cmp_value(cmp_value), .start_timer(start_timer), .timer_en(timer_en),
      .interrupt_en(interrupt_en), .auto_reload(auto_reload),
      .done(done), .irq(irq), .counter(counter), .irq_o(irq_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ten = 0; m_ien = 0; m_ar = 0; m_start = 0; m_done = 0; m_irq = 0;
      m_cmp = '0; m_shadow = '0; m_hold = '0;
   endtask

   task automatic check_outputs();
      chk("outputs", {cmp_value, timer_en, interrupt_en, auto_reload, start_timer, irq_o},
          {m_cmp, m_ten, m_ien, m_ar, m_start, m_irq});
   endtask

   // One bus cycle: check visible state, drive inputs, predict response, advance model
   task automatic cycle(input bit rq, input bit w, input logic [4:0] a, input logic [31:0] wd,
                        input bit dn, input bit ir, input logic [63:0] cnt);
      int unsigned o;
      bit          bad;
      bit [31:0]   rd;
      bit [1:0]    clr;
      @(negedge clk);
      check_outputs();
      req = rq; we = w; addr = a; wdata = wd; done = dn; irq = ir; counter = cnt;
      #1 chk("gnt", 64'(gnt), 64'(rq));
      o   = 32'(a[4:2]);
      bad = (a[1:0] != 0) || (o > 5) || (w && o >= 4);
      rd  = 0;
      if (rq && !w && !bad) begin
         case (o)
            0: rd = {29'b0, m_ar, m_ien, m_ten};
            1: rd = {30'b0, m_irq, m_done};
            2: rd = m_shadow;
            3: rd = m_cmp[63:32];
            4: rd = cnt[31:0];
`ifdef TIMER_REGS_SNAPSHOT_EN
            default: rd = m_hold;
`else
            default: rd = cnt[63:32];
`endif
         endcase
      end
      if (rq) exp_q.push_back('{rdata: rd, err: bad});
      m_start = 0;
      clr     = 0;
      if (rq && w && !bad) begin
         case (o)
            0: begin m_ten = wd[0]; m_ien = wd[1]; m_ar = wd[2]; m_start = wd[3]; end
            1: clr = wd[1:0];
            2: m_shadow = wd;
            default: m_cmp = {wd, m_shadow};
         endcase
      end
      if (rq && !w && !bad && o == 4) m_hold = cnt[63:32];
      if (clr[0]) m_done = 0;
      if (clr[1]) m_irq = 0;
      if (dn) m_done = 1;
      if (ir) m_irq = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 5'h0, 32'h0, 0, 0, counter);
   endtask

   // Reset asserted in the middle of a CTRL start write
   task automatic reset_mid_write();
      @(negedge clk);
      check_outputs();
      req = 1; we = 1; addr = 5'h00; wdata = 32'hF; done = 0; irq = 0;
      #2 rst = 1;
      #1 chk("rst_async", {rvalid, err, rdata, cmp_value, start_timer, timer_en,
                           interrupt_en, auto_reload, irq_o}, '0);
      @(posedge clk);
      #1 chk("rst_edge", {rvalid, err, rdata, cmp_value, start_timer, timer_en,
                          interrupt_en, auto_reload, irq_o}, '0);
      @(negedge clk);
      req = 0; we = 0; rst = 0;
      model_reset();
   endtask

   // Scoreboard monitor: every response beat must match the oldest prediction
   always @(negedge clk) begin
      if (rvalid) begin
         resp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rdata 0x%0h err %0d with no request pending",
                     rdata, err);
         end else begin
            e = exp_q.pop_front();
            chk("resp", {rdata, err}, {e.rdata, e.err});
         end
      end
   end

   initial begin
      logic [63:0] cnt;
      bit          rq, w, dn, ir;
      logic [4:0]  a;
      rst = 1; req = 0; we = 0; addr = 0; wdata = 0; done = 0; irq = 0; counter = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", {rvalid, err, rdata, cmp_value, start_timer, timer_en,
                          interrupt_en, auto_reload, irq_o}, '0);
      rst = 0;

      // compare value commit
      cycle(1, 1, 5'h08, 32'h10, 0, 0, 64'h0);
      idle(1);
      chk("cmp_after_lo", cmp_value, 64'h0);
      cycle(1, 1, 5'h0C, 32'h1, 0, 0, 64'h0);
      idle(1);
      chk("cmp_after_hi", cmp_value, 64'h0000_0001_0000_0010);
      cycle(1, 0, 5'h08, 32'h0, 0, 0, 64'h0);
      cycle(1, 0, 5'h0C, 32'h0, 0, 0, 64'h0);

      // CTRL with start
      cycle(1, 1, 5'h00, 32'hF, 0, 0, 64'h0);
      idle(1);
      chk("start_pulse", {start_timer, timer_en, interrupt_en, auto_reload}, 4'hF);
      idle(1);
      chk("start_cleared", 64'(start_timer), 64'h0);
      cycle(1, 0, 5'h00, 32'h0, 0, 0, 64'h0);
      cycle(1, 1, 5'h00, 32'h8, 0, 0, 64'h0);
      cycle(1, 1, 5'h00, 32'h9, 0, 0, 64'h0);
      idle(3);

      // sticky irq and W1C
      cycle(0, 0, 5'h00, 32'h0, 0, 1, 64'h0);
      cycle(1, 0, 5'h04, 32'h0, 0, 0, 64'h0);
      chk("irq_o_set", 64'(irq_o), 64'h1);
      cycle(1, 1, 5'h04, 32'h2, 0, 1, 64'h0);
      idle(1);
      chk("irq_o_set_wins", 64'(irq_o), 64'h1);
      cycle(1, 1, 5'h04, 32'h2, 0, 0, 64'h0);
      idle(1);
      chk("irq_o_cleared", 64'(irq_o), 64'h0);
      cycle(0, 0, 5'h00, 32'h0, 1, 0, 64'h0);
      cycle(1, 1, 5'h04, 32'h1, 1, 0, 64'h0);
      cycle(1, 1, 5'h04, 32'h1, 0, 0, 64'h0);
      cycle(1, 0, 5'h04, 32'h0, 0, 0, 64'h0);

      // error cases
      cycle(1, 0, 5'h18, 32'h0, 0, 0, 64'h0);
      cycle(1, 1, 5'h10, 32'hFFFF_FFFF, 0, 0, 64'h0);
      cycle(1, 0, 5'h01, 32'h0, 0, 0, 64'h0);
      cycle(1, 1, 5'h02, 32'hF, 0, 0, 64'h0);
      cycle(1, 1, 5'h1C, 32'hF, 0, 0, 64'h0);

      // counter snapshot across a 32-bit wrap
      cycle(1, 0, 5'h10, 32'h0, 0, 0, 64'h1_FFFF_FFFF);
      cycle(1, 0, 5'h14, 32'h0, 0, 0, 64'h2_0000_0000);
      idle(2);

      // random traffic with a reset in the middle
      cnt = 64'hFFFF_FFF0;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            cycle(1, 1, 5'h00, 32'h7, 0, 0, cnt);
            reset_mid_write();
         end
         rq = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 7) == 0) a = 5'($urandom_range(0, 31));
         else a = {3'($urandom_range(0, 5)), 2'b00};
         dn = ($urandom_range(0, 9) == 0);
         ir = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 63) == 0) cnt = {32'($urandom_range(0, 7)), 32'hFFFF_FFFC};
         else cnt = cnt + 64'($urandom_range(0, 3));
         cycle(rq, w, a, $urandom, dn, ir, cnt);
      end
      idle(3);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/timer_regs.md
TIMER_REGS -- requirements
Module: timer_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte-address width of the bus port.
REQ-002 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req in 1, we in 1, addr in ADDR_W, wdata in 32: bus request, write strobe, byte address, write data.
REQ-005 SHALL have ports gnt out 1, rvalid out 1, rdata out 32, err out 1: grant, response valid, read data, error.
REQ-006 SHALL have ports cmp_value out 64, start_timer out 1, timer_en out 1, interrupt_en out 1, auto_reload out 1, which drive the timer.
REQ-007 SHALL have ports done in 1, irq in 1, counter in 64, which come from the timer.
REQ-008 SHALL have port irq_o out 1, the sticky interrupt to the CPU.

Function
REQ-009 SHALL drive gnt combinationally equal to req, accepting one request per cycle.
REQ-010 SHALL assert rvalid for exactly one cycle, one cycle after every granted request; rdata and err are valid only with rvalid.
REQ-011 SHALL decode addr[4:2]: 0 CTRL, 1 STATUS, 2 CMP_LO, 3 CMP_HI, 4 COUNT_LO, 5 COUNT_HI; 6-7 unmapped.
REQ-012 SHALL set err for unmapped offsets, addr[1:0]!=0, or writes to COUNT_LO/HI; no state changes, rdata=0.
REQ-013 CTRL: bit0 timer_en, bit1 interrupt_en, bit2 auto_reload (RW); bit3 start, write-1 pulse, reads 0; bits 31:4 read 0.
REQ-014 A CTRL write with bit3=1 SHALL produce start_timer=1 for exactly one cycle, the cycle after acceptance; CTRL fields update on that same edge.
REQ-015 Back-to-back CTRL start writes SHALL give one pulse per write, so consecutive writes give consecutive high cycles.
REQ-016 STATUS: bit0 done_flag, bit1 irq_flag, write-1-to-clear, bits 31:2 read 0.
REQ-017 done_flag SHALL set on every cycle done=1; irq_flag SHALL set on every cycle irq=1.
REQ-018 A set and a W1C clear of the same flag in the same cycle SHALL leave the flag set.
REQ-019 irq_o SHALL equal irq_flag, registered, with no combinational path from irq.
REQ-020 A CMP_LO write SHALL load only a 32-bit shadow; cmp_value is unchanged.
REQ-021 A CMP_HI write SHALL update cmp_value to {wdata, shadow} in one edge; no partial 64-bit value ever appears.
REQ-022 CMP_LO reads SHALL return the shadow; CMP_HI reads SHALL return cmp_value[63:32].
REQ-023 COUNT_LO reads SHALL return counter[31:0], sampled on the acceptance edge.
REQ-024 Read data SHALL reflect register state before any same-cycle update.

Reset
REQ-025 On rst SHALL immediately clear: timer_en, interrupt_en, auto_reload, start_timer, cmp_value, shadow, done_flag, irq_flag, irq_o, rvalid, err, rdata.
REQ-026 A request accepted in the cycle rst asserts SHALL be discarded with no rvalid; a pending start pulse is cancelled.

Configuration
REQ-027 With macro TIMER_REGS_SNAPSHOT_EN defined, a COUNT_LO read SHALL latch counter[63:32] into a hold register; COUNT_HI reads SHALL return that hold register, which resets to 0.
REQ-028 Without TIMER_REGS_SNAPSHOT_EN, COUNT_HI reads SHALL return live counter[63:32]; there is no hold register.

Verification
REQ-029 Write CMP_LO=0x10, then CMP_HI=0x1 -> cmp_value stays 0 after the first write, then becomes 0x0000_0001_0000_0010 after the second.
REQ-030 Write CTRL=0xF -> timer_en, interrupt_en and auto_reload are 1 and start_timer is high exactly one cycle; CTRL reads back 0x7.
REQ-031 Pulse irq for 1 cycle -> irq_o=1 and STATUS reads 0x2; write STATUS=0x2 while irq=1 -> flag stays set; repeat with irq=0 -> irq_o=0.
REQ-032 Read addr 0x18 and write addr 0x10 -> err=1 with rvalid; read addr 0x01 -> err=1; no state changes in any case.
REQ-033 SNAPSHOT_EN: counter=0x1_FFFF_FFFF, read COUNT_LO, counter then wraps to 0x2_0000_0000, read COUNT_HI -> returns 0x1 (live build returns 0x2).
REQ-034 Assert rst mid CTRL start write -> no start_timer pulse, no rvalid, and all outputs are 0 during reset.
